// File: rtl/ttc_prescaler_lite.sv
// ttc_prescaler_lite
//    Clock-source selector and programmable prescaler for one timer/counter
//    channel. Produces the single-cycle count_en strobe for the channel's
//    16-bit counter. The tick source is either every pclk cycle or a
//    synchronised edge of ext_clk. The tick rate can optionally be divided
//    by 2^(N+1).
//
// Ports
//    pclk             in   system clock (sole clock)
//    p_reset          in   synchronous active-high reset
//    pwdata[15:0]     in   write data, only [6:0] used
//    clk_ctrl_reg_sel in   write strobe for the clock control register
//    cntr_restart     in   restart request from the counter control
//    ext_clk          in   external clock pin, asynchronous to pclk
//    clk_ctrl_reg_out out  clock control register readback
//                          [0] prescale en, [4:1] N, [5] ext src, [6] falling
//    count_en         out  registered one-cycle count strobe
module ttc_prescaler_lite #(
   parameter int PRESC_W = 16
) (
   input  logic        pclk,
   input  logic        p_reset,
   input  logic [15:0] pwdata,
   input  logic        clk_ctrl_reg_sel,
   input  logic        cntr_restart,
   input  logic        ext_clk,
   output logic [6:0]  clk_ctrl_reg_out,
   output logic        count_en
);

   logic [6:0]         clk_ctrl_reg;
   logic               ext_p0;        // s1: first synchroniser flop
   logic               ext_p1;        // s2: synchronised ext_clk
   logic               ext_p2;        // s3: s2 delayed, for edge detect
   logic [PRESC_W-1:0] pcnt;
   logic [PRESC_W-1:0] term;
   logic               ext_rise;
   logic               ext_fall;
   logic               tick;
   logic               unused_pwdata;

   assign unused_pwdata = ^pwdata[15:7];

   // Terminal count 2^(N+1)-1. The shift is done at full counter width so
   // N = 15 wraps 1<<16 to zero and the subtraction yields all ones.
   function automatic logic [PRESC_W-1:0] terminal(input logic [3:0] n);
      logic [PRESC_W-1:0] one;
      one = {{(PRESC_W-1){1'b0}}, 1'b1};
      return (one << ({1'b0, n} + 5'd1)) - one;
   endfunction

   assign clk_ctrl_reg_out = clk_ctrl_reg;
   assign term             = terminal(clk_ctrl_reg[4:1]);
   assign ext_rise         = ext_p1 & ~ext_p2;
   assign ext_fall         = ~ext_p1 & ext_p2;

   always_comb begin
      tick = 1'b1;
      if (clk_ctrl_reg[5])
         tick = clk_ctrl_reg[6] ? ext_fall : ext_rise;
   end

   // Synchroniser stages run every cycle regardless of the source select
   always_ff @(posedge pclk) begin
      if (p_reset) begin
         ext_p0 <= 1'b0;
         ext_p1 <= 1'b0;
         ext_p2 <= 1'b0;
      end else begin
         ext_p0 <= ext_clk;
         ext_p1 <= ext_p0;
         ext_p2 <= ext_p1;
      end
   end

   // Control register and prescale counter / count strobe
   always_ff @(posedge pclk) begin
      if (p_reset) begin
         clk_ctrl_reg <= 7'h00;
         pcnt         <= '0;
         count_en     <= 1'b0;
      end else begin
         // The register write lands even when a restart is in progress
         if (clk_ctrl_reg_sel)
            clk_ctrl_reg <= pwdata[6:0];

         if (cntr_restart) begin
            pcnt     <= '0;
            count_en <= 1'b1;
         end else if (clk_ctrl_reg_sel) begin
            pcnt     <= '0;
            count_en <= 1'b0;
         end else if (tick) begin
            if (!clk_ctrl_reg[0]) begin
               pcnt     <= '0;
               count_en <= 1'b1;
            end else if (pcnt == term) begin
               pcnt     <= '0;
               count_en <= 1'b1;
            end else begin
               pcnt     <= pcnt + 1'b1;
               count_en <= 1'b0;
            end
         end else begin
            count_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ttc_prescaler_lite.sv
module tb_ttc_prescaler_lite;

   logic        pclk = 1'b0;
   logic        p_reset;
   logic [15:0] pwdata;
   logic        clk_ctrl_reg_sel;
   logic        cntr_restart;
   logic        ext_clk;
   logic [6:0]  clk_ctrl_reg_out;
   logic        count_en;

   always #5 pclk = ~pclk;

   ttc_prescaler_lite #(.PRESC_W(16)) dut (
      .pclk             (pclk),
      .p_reset          (p_reset),
      .pwdata           (pwdata),
      .clk_ctrl_reg_sel (clk_ctrl_reg_sel),
      .cntr_restart     (cntr_restart),
      .ext_clk          (ext_clk),
      .clk_ctrl_reg_out (clk_ctrl_reg_out),
      .count_en         (count_en)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: sampled pin history plus a count of qualifying ticks
   // since the last restart/write; a pulse fires when that count reaches
   // the divide ratio 2^(N+1).
   logic [6:0] m_reg;
   logic       m_ce;
   int         m_ticks;
   logic       m_hist [3];   // [0] newest pin sample ... [2] oldest

   typedef struct {
      logic       sel;
      logic       rst_req;
      logic [6:0] wd;
      logic       exp_ce;
      logic [6:0] exp_reg;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic tk;
      int   div;
      if (p_reset) begin
         m_reg   = 7'h00;
         m_ce    = 1'b0;
         m_ticks = 0;
         m_hist  = '{1'b0, 1'b0, 1'b0};
      end else begin
         div = 1 << (int'(m_reg[4:1]) + 1);
         if (!m_reg[5])      tk = 1'b1;
         else if (!m_reg[6]) tk = m_hist[1] & !m_hist[2];
         else                tk = !m_hist[1] & m_hist[2];
         if (cntr_restart) begin
            m_ce = 1'b1; m_ticks = 0;
         end else if (clk_ctrl_reg_sel) begin
            m_ce = 1'b0; m_ticks = 0;
         end else if (tk) begin
            if (!m_reg[0]) m_ce = 1'b1;
            else begin
               m_ticks++;
               if (m_ticks == div) begin m_ce = 1'b1; m_ticks = 0; end
               else m_ce = 1'b0;
            end
         end else begin
            m_ce = 1'b0;
         end
         if (clk_ctrl_reg_sel) m_reg = pwdata[6:0];
         m_hist[2] = m_hist[1];
         m_hist[1] = m_hist[0];
         m_hist[0] = ext_clk;
      end
   endtask

   task automatic cyc();
      @(posedge pclk);
      model_edge();
      @(negedge pclk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_ce"}, count_en, m_ce);
      chk({tag, "_reg"}, clk_ctrl_reg_out, m_reg);
   endtask

   task automatic idle();
      clk_ctrl_reg_sel = 1'b0;
      cntr_restart     = 1'b0;
      pwdata           = 16'($urandom);
   endtask

   task automatic write_reg(input logic [6:0] v);
      clk_ctrl_reg_sel = 1'b1;
      cntr_restart     = 1'b0;
      pwdata           = {9'h0, v};
   endtask

   task automatic addv(input logic s, input logic r, input logic [6:0] wd,
                       input logic ce, input logic [6:0] rg);
      vec_t v;
      v.sel = s; v.rst_req = r; v.wd = wd; v.exp_ce = ce; v.exp_reg = rg;
      vecs.push_back(v);
   endtask

   initial begin
      int pulses, n_edges, gap;
      logic prev, nxt, found;

      p_reset = 1'b1; ext_clk = 1'b0;
      clk_ctrl_reg_sel = 1'b0; cntr_restart = 1'b0; pwdata = 16'h0;
      cyc();
      cyc();
      chk("reset_ce", count_en, 0);
      chk("reset_reg", clk_ctrl_reg_out, 0);
      p_reset = 1'b0;

      // ---- table: bypass, /8, write+restart with /4, held restart ----
      addv(1, 0, 7'h00, 0, 7'h00);
      addv(0, 0, 7'h7F, 1, 7'h00);
      addv(0, 0, 7'h7F, 1, 7'h00);
      addv(1, 0, 7'h05, 0, 7'h05);
      for (int i = 0; i < 7; i++) addv(0, 0, 7'h7F, 0, 7'h05);
      addv(0, 0, 7'h7F, 1, 7'h05);
      for (int i = 0; i < 7; i++) addv(0, 0, 7'h7F, 0, 7'h05);
      addv(0, 0, 7'h7F, 1, 7'h05);
      addv(1, 1, 7'h03, 1, 7'h03);
      for (int i = 0; i < 3; i++) addv(0, 0, 7'h7F, 0, 7'h03);
      addv(0, 0, 7'h7F, 1, 7'h03);
      addv(0, 1, 7'h7F, 1, 7'h03);
      addv(0, 1, 7'h7F, 1, 7'h03);
      for (int i = 0; i < 3; i++) addv(0, 0, 7'h7F, 0, 7'h03);
      addv(0, 0, 7'h7F, 1, 7'h03);
      addv(1, 0, 7'h00, 0, 7'h00);
      addv(0, 0, 7'h7F, 1, 7'h00);

      foreach (vecs[i]) begin
         clk_ctrl_reg_sel = vecs[i].sel;
         cntr_restart     = vecs[i].rst_req;
         pwdata           = {9'h1FF, vecs[i].wd};
         cyc();
         chk($sformatf("vec%0d_ce", i), count_en, vecs[i].exp_ce);
         chk($sformatf("vec%0d_reg", i), clk_ctrl_reg_out, vecs[i].exp_reg);
      end

      // ---- external rising edges at pclk/6 ----
      ext_clk = 1'b0;
      write_reg(7'h20);
      cyc(); chk_model("ext_wr");
      pulses = 0; n_edges = 0; prev = 1'b0;
      for (int i = 0; i < 40; i++) begin
         idle();
         nxt = ((i % 6) >= 3);
         if (nxt && !prev) n_edges++;
         ext_clk = nxt; prev = nxt;
         cyc(); chk_model("ext_rise");
         if (count_en) pulses++;
      end
      for (int i = 0; i < 4; i++) begin
         idle(); cyc(); chk_model("ext_rise_settle");
         if (count_en) pulses++;
      end
      chk("rise_pulses", pulses, n_edges);

      // ---- external falling edges ----
      write_reg(7'h60);
      cyc(); chk_model("ext_wr2");
      pulses = 0; n_edges = 0;
      for (int i = 0; i < 40; i++) begin
         idle();
         nxt = ((i % 6) >= 3);
         if (!nxt && prev) n_edges++;
         ext_clk = nxt; prev = nxt;
         cyc(); chk_model("ext_fall");
         if (count_en) pulses++;
      end
      for (int i = 0; i < 4; i++) begin
         idle(); cyc(); chk_model("ext_fall_settle");
         if (count_en) pulses++;
      end
      chk("fall_pulses", pulses, n_edges);

      // ---- restart during /65536 ----
      write_reg(7'h1F);
      cyc(); chk_model("div64k_wr");
      for (int i = 0; i < 100; i++) begin
         idle(); cyc(); chk_model("div64k_run");
      end
      clk_ctrl_reg_sel = 1'b0; cntr_restart = 1'b1;
      cyc(); chk("restart1_ce", count_en, 1);
      cyc(); chk("restart2_ce", count_en, 1);
      cntr_restart = 1'b0;
      gap = 0; found = 1'b0;
      for (int i = 0; i < 70000 && !found; i++) begin
         idle(); cyc(); gap++;
         if (count_en != m_ce) chk("div64k_model_ce", count_en, m_ce);
         if (count_en) found = 1'b1;
      end
      chk("div64k_found", found, 1);
      chk("div64k_gap", gap, 65536);

      // ---- reset in the middle of a /4 period ----
      write_reg(7'h03);
      cyc();
      for (int i = 0; i < 3; i++) begin idle(); cyc(); end
      p_reset = 1'b1;
      cyc();
      chk("midrst_ce", count_en, 0);
      chk("midrst_reg", clk_ctrl_reg_out, 0);
      p_reset = 1'b0;
      cyc(); chk("post_rst_ce1", count_en, 1);
      cyc(); chk("post_rst_ce2", count_en, 1);
      chk_model("post_rst");

      // ---- randomized against the model ----
      for (int i = 0; i < 4000; i++) begin
         p_reset          = ($urandom_range(0, 299) == 0);
         clk_ctrl_reg_sel = ($urandom_range(0, 39) == 0);
         cntr_restart     = ($urandom_range(0, 59) == 0);
         pwdata           = 16'($urandom);
         if ($urandom_range(0, 3) != 0) pwdata[4:1] = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0) ext_clk = ~ext_clk;
         cyc(); chk_model("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
